// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Data wins by default; a saturating starvation counter forces a fetch grant; aborted fetch responses are dropped.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    input  logic        if_abort,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ready,
    output logic [63:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_starve_cnt;
    logic               r_abort;
    logic               r_if_ready;
    logic [31:0]        r_if_rdata;
    logic               r_d_ready;
    logic [63:0]        r_d_rdata;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [63:0]        r_mem_addr;
    logic [63:0]        r_mem_wdata;

    logic w_f_elig;
    logic w_d_elig;
    logic w_starved;
    logic w_grant_f;
    logic w_grant_d;

    // A requester is not re-granted on its own ready cycle
    assign w_f_elig  = if_req & ~r_if_ready & ~if_abort;
    assign w_d_elig  = d_req & ~r_d_ready;
    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
    assign w_grant_f = w_f_elig & (~w_d_elig | w_starved);
    assign w_grant_d = w_d_elig & ~w_grant_f;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_abort      <= 1'b0;
            r_if_ready   <= 1'b0;
            r_if_rdata   <= '0;
            r_d_ready    <= 1'b0;
            r_d_rdata    <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_abort <= 1'b0;
                    if (w_grant_f) begin
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= if_addr;
                        r_mem_wdata  <= '0;
                        r_starve_cnt <= '0;
                        r_state      <= BUSY_F;
                    end else if (w_grant_d) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_state     <= BUSY_D;
                        // Count only data wins that kept a waiting fetch out
                        if (!w_f_elig) begin
                            r_starve_cnt <= '0;
                        end else if (!w_starved) begin
                            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                        end
                    end
                end
                BUSY_F: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_abort   <= 1'b0;
                        r_state   <= IDLE;
                        if (!(r_abort || if_abort)) begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= mem_rdata[31:0];
                        end
                    end else if (if_abort) begin
                        r_abort <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_d_ready <= 1'b1;
                        r_state   <= IDLE;
                        if (!r_mem_we) begin
                            r_d_rdata <= mem_rdata;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign if_ready  = r_if_ready;
    assign if_rdata  = r_if_rdata;
    assign d_ready   = r_d_ready;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus corner-case sequences, with a
// grant/response scoreboard fed by the stimulus and drained by a negedge monitor.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_abort, if_ready;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        d_req, d_we, d_ready;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } gnt_t;

    typedef struct {
        logic        is_f;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          lat;
    } vec_t;

    gnt_t        gq[$];
    logic [63:0] dq[$];
    logic [31:0] fq[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_d = '0;

    // Memory responder: automatic ack after mem_lat cycles, or manual drive
    logic        auto_mem = 1'b1;
    int          mem_lat  = 1;
    int          mcnt     = 0;
    logic        a_ack    = 1'b0;
    logic [63:0] a_rdata  = '0;
    logic        m_ack    = 1'b0;
    logic [63:0] m_rdata  = '0;

    assign mem_ack   = auto_mem ? a_ack   : m_ack;
    assign mem_rdata = auto_mem ? a_rdata : m_rdata;

    function automatic logic [63:0] model(input logic [63:0] a);
        if (a == 64'h2000) return 64'h1122334455667788;
        return {a[31:0] ^ 32'hC0DEF00D, ~a[31:0]} + 64'h0123;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void push_grant(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
        gnt_t g;
        g.we = we; g.addr = addr; g.wdata = wdata;
        gq.push_back(g);
    endfunction

    always @(negedge clk) begin
        if (!auto_mem) begin
            a_ack = 1'b0;
            mcnt  = 0;
        end else if (a_ack) begin
            a_ack = 1'b0;
        end else if (mem_req) begin
            mcnt++;
            if (mcnt >= mem_lat) begin
                a_ack   = 1'b1;
                a_rdata = model(mem_addr);
                mcnt    = 0;
            end
        end else begin
            mcnt = 0;
        end
    end

    // Monitor: compare each new grant and each ready pulse against the queues
    logic prev_mreq = 1'b0, prev_dr = 1'b0, prev_fr = 1'b0;
    always @(negedge clk) begin
        gnt_t g;
        if (mem_req && !prev_mreq) begin
            if (gq.size() == 0) chk("grant_unexpected", 64'(gq.size()), 64'd1);
            else begin
                g = gq.pop_front();
                chk("grant_we", 64'(mem_we), 64'(g.we));
                chk("grant_addr", mem_addr, g.addr);
                chk("grant_wdata", mem_wdata, g.wdata);
            end
        end
        if (d_ready) begin
            chk("d_ready_pulse", 64'(prev_dr), 64'd0);
            if (dq.size() == 0) chk("d_ready_unexpected", 64'(dq.size()), 64'd1);
            else chk("d_rdata", d_rdata, dq.pop_front());
        end
        if (if_ready) begin
            chk("if_ready_pulse", 64'(prev_fr), 64'd0);
            if (fq.size() == 0) chk("if_ready_unexpected", 64'(fq.size()), 64'd1);
            else chk("if_rdata", 64'(if_rdata), 64'(fq.pop_front()));
        end
        prev_mreq = mem_req;
        prev_dr   = d_ready;
        prev_fr   = if_ready;
    end

    task automatic wait_ready(input bit is_f, input string name);
        int  c = 0;
        bit  got = 1'b0;
        while (!got && c < 60) begin
            @(negedge clk);
            c++;
            got = is_f ? if_ready : d_ready;
        end
        if (!got) chk(name, 64'd0, 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [63:0] m;
        int c = 0;
        bit got = 1'b0;
        mem_lat = v.lat;
        @(negedge clk);
        m = model(v.addr);
        if (v.is_f) begin
            if_req = 1'b1; if_addr = v.addr;
            push_grant(1'b0, v.addr, 64'd0);
            fq.push_back(m[31:0]);
        end else begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
            push_grant(v.we, v.addr, v.wdata);
            if (!v.we) exp_d = m;
            dq.push_back(exp_d);
        end
        while (!got && c < 60) begin
            @(negedge clk);
            c++;
            got = v.is_f ? if_ready : d_ready;
        end
        chk("vec_latency", 64'(c), 64'(v.lat + 1));
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        logic [63:0] m;
        logic [31:0] saved_if;

        vecs[0] = '{1'b0, 1'b0, 64'h2000,                64'h0,                  2};
        vecs[1] = '{1'b0, 1'b1, 64'h2008,                64'hCAFEBABE00001111,   1};
        vecs[2] = '{1'b1, 1'b0, 64'h1000,                64'h0,                  1};
        vecs[3] = '{1'b0, 1'b0, 64'h3008,                64'h55,                 3};
        vecs[4] = '{1'b1, 1'b0, 64'h0,                   64'h0,                  4};
        vecs[5] = '{1'b0, 1'b1, 64'hFFFFFFFFFFFFFFF8,    64'hFFFFFFFFFFFFFFFF,   2};
        vecs[6] = '{1'b0, 1'b0, 64'hFFFFFFFFFFFFFFF8,    64'h0,                  1};
        vecs[7] = '{1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFC,    64'h0,                  2};

        reset = 1'b1;
        if_req = 1'b0; if_abort = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_if_ready", 64'(if_ready), 64'd0);
        chk("rst_d_ready", 64'(d_ready), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_if_rdata", 64'(if_rdata), 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Collision: store wins, fetch follows in the store's ready cycle
        mem_lat = 2;
        @(negedge clk);
        if_req = 1'b1; if_addr = 64'h2004;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h3000; d_wdata = 64'hDEAD;
        push_grant(1'b1, 64'h3000, 64'hDEAD);
        push_grant(1'b0, 64'h2004, 64'h0);
        dq.push_back(exp_d);
        m = model(64'h2004);
        fq.push_back(m[31:0]);
        wait_ready(1'b0, "collision_d_timeout");
        d_req = 1'b0;
        wait_ready(1'b1, "collision_f_timeout");
        if_req = 1'b0;

        // Starvation: if_abort blanks fetch on each d_ready cycle so data keeps winning
        mem_lat = 1;
        @(negedge clk);
        if_req = 1'b1; if_addr = 64'h4000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h5000; d_wdata = 64'h0;
        for (int i = 0; i < 4; i++) begin
            push_grant(1'b0, 64'h5000 + 64'(8 * i), 64'h0);
            exp_d = model(64'h5000 + 64'(8 * i));
            dq.push_back(exp_d);
        end
        push_grant(1'b0, 64'h4000, 64'h0);
        m = model(64'h4000);
        fq.push_back(m[31:0]);
        push_grant(1'b0, 64'h5020, 64'h0);
        exp_d = model(64'h5020);
        dq.push_back(exp_d);
        for (int i = 0; i < 4; i++) begin
            wait_ready(1'b0, "starve_d_timeout");
            if_abort = 1'b1;
            d_addr = 64'h5000 + 64'(8 * (i + 1));
            @(negedge clk);
            if_abort = 1'b0;
        end
        wait_ready(1'b1, "starve_f_timeout");
        if_req = 1'b0;
        wait_ready(1'b0, "starve_resume_timeout");
        d_req = 1'b0;

        // Abort one cycle before ack: no if_ready, data granted next IDLE
        mem_lat = 3;
        @(negedge clk);
        saved_if = if_rdata;
        if_req = 1'b1; if_addr = 64'h6000;
        push_grant(1'b0, 64'h6000, 64'h0);
        repeat (2) @(negedge clk);
        if_abort = 1'b1;
        @(negedge clk);
        if_abort = 1'b0; if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h7000; d_wdata = 64'h0;
        push_grant(1'b0, 64'h7000, 64'h0);
        exp_d = model(64'h7000);
        dq.push_back(exp_d);
        @(negedge clk);
        chk("abort_mem_req_drop", 64'(mem_req), 64'd0);
        chk("abort_no_if_ready", 64'(if_ready), 64'd0);
        @(negedge clk);
        chk("abort_next_grant", 64'(mem_req), 64'd1);
        wait_ready(1'b0, "abort_d_timeout");
        d_req = 1'b0;
        chk("abort_if_rdata_kept", 64'(if_rdata), 64'(saved_if));

        // Reset in the middle of a data access, then a late ack
        @(negedge clk);
        auto_mem = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h8000;
        push_grant(1'b0, 64'h8000, 64'h0);
        @(negedge clk);
        chk("rstmid_busy", 64'(mem_req), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstmid_mem_req", 64'(mem_req), 64'd0);
        chk("rstmid_d_ready", 64'(d_ready), 64'd0);
        chk("rstmid_if_ready", 64'(if_ready), 64'd0);
        chk("rstmid_d_rdata", d_rdata, 64'd0);
        d_req = 1'b0;
        exp_d = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        m_ack = 1'b1; m_rdata = 64'hBADBADBADBADBAD0;
        @(negedge clk);
        m_ack = 1'b0;
        chk("late_ack_d_ready", 64'(d_ready), 64'd0);
        chk("late_ack_mem_req", 64'(mem_req), 64'd0);
        auto_mem = 1'b1;
        run_vec('{1'b0, 1'b0, 64'h8008, 64'h0, 2});

        // Held for the ready cycle only: no second grant
        mem_lat = 1;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h9000; d_wdata = 64'h0;
        push_grant(1'b0, 64'h9000, 64'h0);
        exp_d = model(64'h9000);
        dq.push_back(exp_d);
        wait_ready(1'b0, "held1_timeout");
        @(negedge clk);
        chk("held1_no_regrant", 64'(mem_req), 64'd0);
        d_req = 1'b0;
        @(negedge clk);
        chk("held1_still_idle", 64'(mem_req), 64'd0);

        // Held into the following IDLE cycle: second grant
        d_req = 1'b1; d_addr = 64'h9008;
        push_grant(1'b0, 64'h9008, 64'h0);
        exp_d = model(64'h9008);
        dq.push_back(exp_d);
        wait_ready(1'b0, "held2a_timeout");
        push_grant(1'b0, 64'h9008, 64'h0);
        dq.push_back(exp_d);
        @(negedge clk);
        chk("held2_no_grant_in_ready", 64'(mem_req), 64'd0);
        wait_ready(1'b0, "held2b_timeout");
        d_req = 1'b0;

        // Stray ack while IDLE
        @(negedge clk);
        auto_mem = 1'b0;
        m_ack = 1'b1; m_rdata = 64'h1234;
        @(negedge clk);
        m_ack = 1'b0;
        chk("stray_ack_d_ready", 64'(d_ready), 64'd0);
        chk("stray_ack_if_ready", 64'(if_ready), 64'd0);
        chk("stray_ack_mem_req", 64'(mem_req), 64'd0);
        auto_mem = 1'b1;

        repeat (3) @(negedge clk);
        chk("gq_drained", 64'(gq.size()), 64'd0);
        chk("dq_drained", 64'(dq.size()), 64'd0);
        chk("fq_drained", 64'(fq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
